// File: rtl/genbus_sram_slave.sv
// Byte-laned 16-bit SRAM slave for the genbus master protocol, with address-window decode and programmable wait states.
// Optional write protect (wp input, sticky wp_viol output) is enabled by defining GENBUS_SRAM_WP_EN.
module genbus_sram_slave #(
  parameter logic [15:0] BASE_ADR    = 16'h0000,
  parameter int unsigned ADR_BITS    = 4,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ID          = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] adr,
  input  logic [1:0]  we,
  input  logic [1:0]  re,
  input  logic [15:0] mdata,
`ifdef GENBUS_SRAM_WP_EN
  input  logic        wp,
  output logic        wp_viol,
`endif
  output logic [15:0] sdata,
  output logic        ws,
  output logic [15:0] acc_cnt
);

  localparam int unsigned DEPTH   = 2 ** ADR_BITS;
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic                 hit, req, done, wr_en;
  logic [ADR_BITS-1:0]  idx;
  logic [15:0]          mem [DEPTH];

  // ID is informational and adr[0] selects nothing on a 16-bit word bus.
  logic [32:0] unused_bits;
  assign unused_bits = {32'(ID), adr[0]};

  assign hit = (adr[15:ADR_BITS+1] == BASE_ADR[15:ADR_BITS+1]);
  assign req = hit & ((|we) | (|re));
  assign idx = adr[ADR_BITS:1];

`ifdef GENBUS_SRAM_WP_EN
  assign wr_en = done & ~wp;
`else
  assign wr_en = done;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (done) acc_cnt <= acc_cnt + 16'd1;
    end
  end

  // Wait-state sequencing; ws and done are Mealy on req so a dropped request aborts at once.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ws        = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            done = 1'b1;
          end else begin
            ws        = 1'b1;
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (cnt != 4'd0) begin
          ws      = 1'b1;
          cnt_nxt = cnt - 4'd1;
        end else begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      ws   = 1'b0;
      done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wr_en) begin
      if (we[0]) mem[idx][7:0]  <= mdata[7:0];
      if (we[1]) mem[idx][15:8] <= mdata[15:8];
    end
  end

`ifdef GENBUS_SRAM_WP_EN
  always_ff @(posedge clk) begin
    if (rst)                    wp_viol <= 1'b0;
    else if (done & wp & |we)   wp_viol <= 1'b1;
  end
`endif

  // Read returns pre-write contents; a same-cycle write lands at the closing edge.
  always_comb begin
    sdata = 16'h0000;
    if (done) begin
      if (re[0]) sdata[7:0]  = mem[idx][7:0];
      if (re[1]) sdata[15:8] = mem[idx][15:8];
    end
  end

endmodule

// File: tb/tb_genbus_sram_slave.sv
// Bench for genbus_sram_slave: two instances (1 and 3 wait states) checked against a word-array model.
module tb_genbus_sram_slave;

  logic        clk, rst;
  logic [15:0] adr_a, mdata_a, adr_b, mdata_b;
  logic [1:0]  we_a, re_a, we_b, re_b;
  logic        wp_a, wp_b;
  logic [15:0] sdata_a, sdata_b, acc_a, acc_b;
  logic        ws_a, ws_b;
`ifdef GENBUS_SRAM_WP_EN
  logic        wp_viol_a, wp_viol_b;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] mem_m [2][16];
  logic [15:0] acc_m [2];
  logic        wpv_m [2];

  genbus_sram_slave #(.BASE_ADR(16'h0000), .ADR_BITS(4), .WAIT_STATES(1), .ID(0)) dut_a (
    .clk(clk), .rst(rst), .adr(adr_a), .we(we_a), .re(re_a), .mdata(mdata_a),
`ifdef GENBUS_SRAM_WP_EN
    .wp(wp_a), .wp_viol(wp_viol_a),
`endif
    .sdata(sdata_a), .ws(ws_a), .acc_cnt(acc_a));

  genbus_sram_slave #(.BASE_ADR(16'h0000), .ADR_BITS(4), .WAIT_STATES(3), .ID(1)) dut_b (
    .clk(clk), .rst(rst), .adr(adr_b), .we(we_b), .re(re_b), .mdata(mdata_b),
`ifdef GENBUS_SRAM_WP_EN
    .wp(wp_b), .wp_viol(wp_viol_b),
`endif
    .sdata(sdata_b), .ws(ws_b), .acc_cnt(acc_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_ws(input int s);
    return (s == 0) ? ws_a : ws_b;
  endfunction
  function automatic logic [15:0] get_sdata(input int s);
    return (s == 0) ? sdata_a : sdata_b;
  endfunction
  function automatic logic [15:0] get_acc(input int s);
    return (s == 0) ? acc_a : acc_b;
  endfunction

  task automatic drive(input int s, input logic [15:0] a, input logic [1:0] w, input logic [1:0] r,
                       input logic [15:0] d);
    if (s == 0) begin adr_a = a; we_a = w; re_a = r; mdata_a = d; end
    else        begin adr_b = a; we_b = w; re_b = r; mdata_b = d; end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) mem_m[s][i] = 16'h0000;
      acc_m[s] = 16'h0000;
      wpv_m[s] = 1'b0;
    end
  endtask

  // One full transaction from request to completion; called at posedge+1.
  task automatic access(input int s, input logic [15:0] a, input logic [1:0] w, input logic [1:0] r,
                        input logic [15:0] d, input string tag);
    int          waits, n;
    logic        req, wp_on;
    logic [3:0]  idx;
    logic [15:0] exp_sd;
    waits  = (s == 0) ? 1 : 3;
    req    = (a[15:5] == 11'd0) && ((w != 2'b00) || (r != 2'b00));
    idx    = a[4:1];
    wp_on  = (s == 0) ? wp_a : wp_b;
    n      = req ? waits : 0;
    exp_sd = 16'h0000;
    if (req && r[0]) exp_sd[7:0]  = mem_m[s][idx][7:0];
    if (req && r[1]) exp_sd[15:8] = mem_m[s][idx][15:8];
    drive(s, a, w, r, d);
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      total++;
      if (get_ws(s) !== 1'(c < n)) begin
        bad++;
        $display("FAIL %s ws dut%0d cycle %0d: got %b want %b", tag, s, c, get_ws(s), 1'(c < n));
      end
      if (c == n) begin
        total++;
        if (get_sdata(s) !== exp_sd) begin
          bad++;
          $display("FAIL %s sdata dut%0d: got %h want %h", tag, s, get_sdata(s), exp_sd);
        end
      end
      @(posedge clk); #1;
    end
    if (req) begin
      if (!wp_on) begin
        if (w[0]) mem_m[s][idx][7:0]  = d[7:0];
        if (w[1]) mem_m[s][idx][15:8] = d[15:8];
      end else if (w != 2'b00) begin
        wpv_m[s] = 1'b1;
      end
      acc_m[s] = acc_m[s] + 16'd1;
    end
    total++;
    if (get_acc(s) !== acc_m[s]) begin
      bad++;
      $display("FAIL %s acc_cnt dut%0d: got %h want %h", tag, s, get_acc(s), acc_m[s]);
    end
    drive(s, 16'h0000, 2'b00, 2'b00, 16'h0000);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 16'h0006, 2'b00, 2'b11, 16'h0000);
    drive(1, 16'h0006, 2'b00, 2'b11, 16'h0000);
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (ws_a !== 1'b0 || ws_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_ws: got %b%b want 00", ws_a, ws_b);
    end
    total++;
    if (sdata_a !== 16'h0000 || sdata_b !== 16'h0000) begin
      bad++;
      $display("FAIL reset_sdata: got %h %h want 0000 0000", sdata_a, sdata_b);
    end
    @(posedge clk); #1;
    drive(0, 16'h0000, 2'b00, 2'b00, 16'h0000);
    drive(1, 16'h0000, 2'b00, 2'b00, 16'h0000);
    rst = 1'b0;
    model_reset();
    total++;
    if (acc_a !== 16'h0000 || acc_b !== 16'h0000) begin
      bad++;
      $display("FAIL reset_acc: got %h %h want 0000 0000", acc_a, acc_b);
    end
  endtask

  task automatic test_lanes();
    access(0, 16'h0006, 2'b00, 2'b11, 16'h0000, "rd_word3_init");
    access(0, 16'h0006, 2'b01, 2'b00, 16'hA55A, "wr_lo");
    access(0, 16'h0006, 2'b00, 2'b11, 16'h0000, "rd_lo");
    access(0, 16'h0006, 2'b10, 2'b00, 16'h3C00, "wr_hi");
    access(0, 16'h0006, 2'b00, 2'b11, 16'h0000, "rd_both");
    access(0, 16'h0006, 2'b00, 2'b10, 16'h0000, "rd_hi_only");
  endtask

  task automatic test_wait_abort();
    access(1, 16'h0008, 2'b11, 2'b00, 16'h1357, "ws3_write");
    drive(1, 16'h0008, 2'b00, 2'b11, 16'h0000);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (ws_b !== 1'b1) begin
        bad++;
        $display("FAIL abort_pre_ws cycle %0d: got %b want 1", c, ws_b);
      end
      @(posedge clk); #1;
    end
    drive(1, 16'h0008, 2'b00, 2'b00, 16'h0000);
    @(negedge clk);
    total++;
    if (ws_b !== 1'b0 || sdata_b !== 16'h0000) begin
      bad++;
      $display("FAIL abort_drop: got ws=%b sdata=%h want ws=0 sdata=0000", ws_b, sdata_b);
    end
    @(posedge clk); #1;
    total++;
    if (acc_b !== acc_m[1]) begin
      bad++;
      $display("FAIL abort_acc: got %h want %h", acc_b, acc_m[1]);
    end
    access(1, 16'h0008, 2'b00, 2'b11, 16'h0000, "after_abort");
  endtask

  task automatic test_miss();
    access(0, 16'h0040, 2'b11, 2'b00, 16'hFFFF, "miss_write");
    access(0, 16'h0041, 2'b00, 2'b11, 16'h0000, "miss_read");
    access(0, 16'h0000, 2'b00, 2'b11, 16'h0000, "word0_untouched");
  endtask

  task automatic test_same_lane();
    access(0, 16'h0004, 2'b11, 2'b00, 16'h1234, "wr_word2");
    access(0, 16'h0004, 2'b11, 2'b11, 16'hBEEF, "rmw_old_data");
    access(0, 16'h0004, 2'b00, 2'b11, 16'h0000, "rd_new_data");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      access(1, 16'(2 * i), 2'b11, 2'b00, 16'(16'h1111 * (i + 1)), "b2b_wr");
    end
    for (int i = 0; i < 4; i++) begin
      access(1, 16'(2 * i), 2'b00, 2'b11, 16'h0000, "b2b_rd");
    end
  endtask

  task automatic test_random();
    int          s;
    logic [15:0] a;
    for (int i = 0; i < 80; i++) begin
      s = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      else a = {11'd0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))};
      access(s, a, 2'($urandom), 2'($urandom), 16'($urandom), "random");
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
  endtask

`ifdef GENBUS_SRAM_WP_EN
  task automatic test_wp();
    wp_a = 1'b1;
    access(0, 16'h0002, 2'b11, 2'b00, 16'hFFFF, "wp_write");
    total++;
    if (wp_viol_a !== wpv_m[0]) begin
      bad++;
      $display("FAIL wp_viol_set: got %b want %b", wp_viol_a, wpv_m[0]);
    end
    wp_a = 1'b0;
    access(0, 16'h0002, 2'b00, 2'b11, 16'h0000, "wp_word_kept");
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (wp_viol_a !== 1'b1 || wp_viol_b !== 1'b0) begin
      bad++;
      $display("FAIL wp_viol_sticky: got %b%b want 10", wp_viol_a, wp_viol_b);
    end
  endtask
`endif

  task automatic test_reset_mid_wait();
    drive(1, 16'h000A, 2'b11, 2'b11, 16'hCAFE);
    @(negedge clk);
    total++;
    if (ws_b !== 1'b1) begin
      bad++;
      $display("FAIL midwait_ws: got %b want 1", ws_b);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (ws_b !== 1'b0 || sdata_b !== 16'h0000) begin
      bad++;
      $display("FAIL midwait_rst_ws: got ws=%b sdata=%h want 0 0000", ws_b, sdata_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 16'h0000, 2'b00, 2'b00, 16'h0000);
    model_reset();
    total++;
    if (acc_a !== 16'h0000 || acc_b !== 16'h0000) begin
      bad++;
      $display("FAIL midwait_acc: got %h %h want 0000 0000", acc_a, acc_b);
    end
`ifdef GENBUS_SRAM_WP_EN
    total++;
    if (wp_viol_a !== 1'b0) begin
      bad++;
      $display("FAIL wp_viol_clear: got %b want 0", wp_viol_a);
    end
`endif
    access(1, 16'h000A, 2'b00, 2'b11, 16'h0000, "post_rst_word5");
    access(0, 16'h0004, 2'b00, 2'b11, 16'h0000, "post_rst_word2");
  endtask

  initial begin
    wp_a = 1'b0;
    wp_b = 1'b0;
    model_reset();
    test_reset();
    test_lanes();
    test_wait_abort();
    test_miss();
    test_same_lane();
    test_back_to_back();
    test_random();
`ifdef GENBUS_SRAM_WP_EN
    test_wp();
`endif
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
